// File: rtl/dff_bist.sv
// Built-in self-test for a bank of D flops: resets the DUT, drives LFSR vectors
// and counts matching/mismatching compares of dut_q against a behavioural model.
module dff_bist #(
  parameter int WIDTH     = 8,
  parameter int N_VECTORS = 16,
  parameter bit USE_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_rst,
  output logic [WIDTH-1:0] dut_d,
  output logic             dut_en,
  input  logic [WIDTH-1:0] dut_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      ok_count,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RSTPH = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LAST_VEC  = 16'(N_VECTORS - 1);

  state_t           r_state;
  logic [15:0]      r_lfsr;
  logic [15:0]      r_cnt;
  logic [WIDTH-1:0] r_exp_q;

  logic [15:0] w_lfsr_next;
  logic        w_cmp;
  logic        w_match;
  logic        w_capture;
  logic [15:0] w_ok_next;
  logic [15:0] w_err_next;

  // x^16+x^14+x^13+x^11+1, shifting toward the MSB
  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  // A compare happens on the second reset-phase cycle and on every cycle after a driven vector
  assign w_cmp = ((r_state == S_RSTPH) && r_cnt[0]) ||
                 ((r_state == S_RUN) && (r_cnt != 16'd0)) ||
                 (r_state == S_DRAIN);
  // Case equality so X/Z bits on dut_q never count as a match
  assign w_match   = (dut_q === r_exp_q);
  assign w_capture = dut_en || !USE_EN;

  always_comb begin
    w_ok_next  = ok_count;
    w_err_next = err_count;
    if (w_cmp) begin
      if (w_match) begin
        if (ok_count != 16'hFFFF) w_ok_next = ok_count + 16'd1;
      end else begin
        if (err_count != 16'hFFFF) w_err_next = err_count + 16'd1;
      end
    end
  end

  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lfsr    <= LFSR_SEED;
      r_cnt     <= 16'd0;
      r_exp_q   <= '0;
      dut_rst   <= 1'b1;
      dut_d     <= '0;
      dut_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 16'd0;
      ok_count  <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          dut_rst <= 1'b0;
          if (start) begin
            r_state   <= S_RSTPH;
            r_lfsr    <= LFSR_SEED;
            r_cnt     <= 16'd0;
            r_exp_q   <= '0;
            dut_rst   <= 1'b1;
            dut_d     <= '0;
            dut_en    <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 16'd0;
            ok_count  <= 16'd0;
          end
        end
        S_RSTPH: begin
          r_exp_q   <= '0;
          ok_count  <= w_ok_next;
          err_count <= w_err_next;
          if (r_cnt[0]) begin
            r_state <= S_RUN;
            r_cnt   <= 16'd0;
            dut_rst <= 1'b0;
            dut_d   <= r_lfsr[WIDTH-1:0];
            dut_en  <= r_lfsr[15];
          end else begin
            r_cnt <= 16'd1;
          end
        end
        S_RUN: begin
          if (w_capture) r_exp_q <= dut_d;
          ok_count  <= w_ok_next;
          err_count <= w_err_next;
          r_lfsr    <= w_lfsr_next;
          if (r_cnt == LAST_VEC) begin
            r_state <= S_DRAIN;
            dut_d   <= '0;
            dut_en  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt + 16'd1;
            dut_d  <= w_lfsr_next[WIDTH-1:0];
            dut_en <= w_lfsr_next[15];
          end
        end
        S_DRAIN: begin
          ok_count  <= w_ok_next;
          err_count <= w_err_next;
          r_state   <= S_DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          pass      <= (w_err_next == 16'd0);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bist.sv
// Bench for dff_bist: two instances (enable honoured / ignored) driving
// behavioural flop banks with selectable faults, checked against a vector-level model.
module tb_dff_bist;
  localparam int W  = 8;
  localparam int NV = 16;

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  logic         dut_rst_a, dut_en_a, busy_a, done_a, pass_a;
  logic [W-1:0] dut_d_a, dut_q_a;
  logic [15:0]  err_a, ok_a;
  logic [2:0]   st_a;
  logic         dut_rst_b, dut_en_b, busy_b, done_b, pass_b;
  logic [W-1:0] dut_d_b, dut_q_b;
  logic [15:0]  err_b, ok_b;
  logic [2:0]   st_b;

  dff_bist #(.WIDTH(W), .N_VECTORS(NV), .USE_EN(1'b1)) u_bist_a (
    .clk(clk), .rst(rst), .start(start), .dut_rst(dut_rst_a), .dut_d(dut_d_a),
    .dut_en(dut_en_a), .dut_q(dut_q_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .ok_count(ok_a), .o_dbg_state(st_a));

  dff_bist #(.WIDTH(W), .N_VECTORS(NV), .USE_EN(1'b0)) u_bist_b (
    .clk(clk), .rst(rst), .start(start), .dut_rst(dut_rst_b), .dut_d(dut_d_b),
    .dut_en(dut_en_b), .dut_q(dut_q_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .ok_count(ok_b), .o_dbg_state(st_b));

  // kind: 0 good, 1 stuck FF, 2 ignores enable, 3 bit stuck-1, 4 bit stuck-0
  int           kind = 0;
  logic [W-1:0] fmask = '0;
  logic [W-1:0] fq_a, fq_b;

  always_ff @(posedge clk or posedge dut_rst_a)
    if (dut_rst_a) fq_a <= '0;
    else if (dut_en_a || kind == 2) fq_a <= dut_d_a;

  always_comb begin
    dut_q_a = fq_a;
    case (kind)
      1: dut_q_a = '1;
      3: dut_q_a = fq_a | fmask;
      4: dut_q_a = fq_a & ~fmask;
      default: dut_q_a = fq_a;
    endcase
  end

  always_ff @(posedge clk or posedge dut_rst_b)
    if (dut_rst_b) fq_b <= '0;
    else fq_b <= dut_d_b;
  assign dut_q_b = fq_b;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] observe(input int k, input logic [W-1:0] m, input logic [W-1:0] q);
    case (k)
      1: return '1;
      3: return q | m;
      4: return q & ~m;
      default: return q;
    endcase
  endfunction

  // Vector-level model: replay the seeded LFSR sequence, track what a correct
  // flop should hold and what the faulty bank really shows, and tally compares.
  function automatic void model_run(input int k, input logic [W-1:0] m, input bit use_en,
                                    output int ok, output int err);
    logic [15:0]  l;
    logic [W-1:0] e, q, d;
    logic         en;
    l = 16'hACE1; e = '0; q = '0; ok = 0; err = 0;
    if (observe(k, m, q) == '0) ok++; else err++;
    for (int i = 0; i < NV; i++) begin
      d  = l[W-1:0];
      en = l[15];
      if (en || !use_en) e = d;
      if (en || k == 2) q = d;
      if (observe(k, m, q) == e) ok++; else err++;
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
  endfunction

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!done_a && cycles < 100);
    check("done_timeout", {31'd0, done_a}, 32'd1);
  endtask

  task automatic check_results(input string tag, input int eok, input int eerr);
    check({tag, "_ok"}, {16'd0, ok_a}, eok);
    check({tag, "_err"}, {16'd0, err_a}, eerr);
    check({tag, "_pass"}, {31'd0, pass_a}, (eerr == 0) ? 32'd1 : 32'd0);
    check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    check({tag, "_b_ok"}, {16'd0, ok_b}, NV + 1);
    check({tag, "_b_pass"}, {31'd0, pass_b & done_b}, 32'd1);
  endtask

  task automatic run_and_check(input int k, input int b);
    int eok, eerr, cycles;
    @(negedge clk);
    kind  = k;
    fmask = W'(1 << b);
    model_run(k, fmask, 1'b1, eok, eerr);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
      if (k == 0 && cycles == 2) begin
        check("first_vec_d", {24'd0, dut_d_a}, 32'hE1);
        check("first_vec_en", {31'd0, dut_en_a}, 32'd1);
        check("first_vec_rst", {31'd0, dut_rst_a}, 32'd0);
      end
      if (k == 0 && cycles == 3) check("first_vec_q", {24'd0, dut_q_a}, 32'hE1);
    end while (!done_a && cycles < 100);
    check("done_timeout", {31'd0, done_a}, 32'd1);
    check($sformatf("latency_k%0d", k), cycles, 2 + NV + 1);
    check_results($sformatf("run_k%0d_b%0d", k, b), eok, eerr);
    check("sum", {16'd0, ok_a} + {16'd0, err_a}, NV + 1);
    if (k == 2) check("ignore_en_err_pos", {31'd0, (err_a != 16'd0)}, 32'd1);
  endtask

  initial begin
    int cycles, runs, ok1, err1, eok, eerr;
    logic prev_busy;
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", {29'd0, st_a}, 32'd0);
    check("rst_dut_rst", {31'd0, dut_rst_a}, 32'd1);
    check("rst_dut_d", {24'd0, dut_d_a}, 32'd0);
    check("rst_dut_en", {31'd0, dut_en_a}, 32'd0);
    check("rst_flags", {29'd0, busy_a, done_a, pass_a}, 32'd0);
    check("rst_counts", {ok_a, err_a}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_dut_rst", {31'd0, dut_rst_a}, 32'd0);

    run_and_check(0, 0);
    run_and_check(1, 0);
    run_and_check(2, 0);
    for (int i = 0; i < 6; i++) run_and_check($urandom_range(0, 4), $urandom_range(0, W - 1));

    // Abort in the middle of RUN
    @(negedge clk);
    kind = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy_a}, 32'd0);
    check("abort_counts", {ok_a, err_a}, 32'd0);
    check("abort_dut_rst", {31'd0, dut_rst_a}, 32'd1);
    @(posedge clk); #1;
    check("abort_edge", {28'd0, busy_a, done_a, pass_a, dut_rst_a}, 32'd1);
    check("abort_state", {29'd0, st_a}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_rel_dut_rst", {31'd0, dut_rst_a}, 32'd0);
    run_and_check(0, 0);

    // start held for the whole run
    model_run(0, '0, 1'b1, eok, eerr);
    @(negedge clk);
    start = 1'b1;
    runs = 0;
    prev_busy = 1'b0;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
      if (busy_a && !prev_busy) runs++;
      prev_busy = busy_a;
    end while (!done_a && cycles < 100);
    start = 1'b0;
    check("held_done", {31'd0, done_a}, 32'd1);
    @(posedge clk); #1;
    check("held_runs", runs, 32'd1);
    check("held_idle", {30'd0, busy_a, done_a}, 32'd1);
    check_results("held", eok, eerr);
    ok1 = ok_a;
    err1 = err_a;

    // Restart from DONE
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_clear", {13'd0, busy_a, done_a, pass_a, ok_a | err_a}, 32'h40000);
    wait_done(cycles);
    check("restart_ok", {16'd0, ok_a}, ok1);
    check("restart_err", {16'd0, err_a}, err1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
